pga_spi_responder: RTL and testbench
====================================

Name: pga_spi_responder

Overview:
- Serial-peripheral end of the PGA gain-setting link: a behavioural and synthesizable SPI responder.
- Clocked by the same `sck` that the PGA master drives. Deserializes MSB-first frames qualified by `cs_n`, and commits the gain code only on a correctly sized frame.
- Flags short and long frames.
- Provides a read-back shift output (`sdo`) carrying the previously committed code.
- Used as the PGA model in block-level benches and as a loopback checker on the receiver board.

Parameters:
- WIDTH, 8, frame length in bits and width of the gain code.
- RESET_CODE, 8'h00, value loaded into `gain_o` on reset; width WIDTH.
- CNT_W, 8, width of the good-frame counter.

Ports:
- sck  input  1  the single clock; all logic on posedge sck.
- rst  input  1  synchronous active-high reset, sampled on posedge sck.
- cs_n  input  1  active-low chip select from master; synchronous to sck.
- sdi  input  1  serial data from master; MSB first; sampled on posedge sck while cs_n=0.
- sdo  output  1  read-back serial data; MSB of the read-back shift register.
- gain_o  output  WIDTH  last committed gain code.
- valid_o  output  1  one-cycle pulse when gain_o is updated.
- frame_err_o  output  1  sticky; set on short or long frame.
- busy_o  output  1  high while in SHIFT or OVERRUN.
- frame_cnt_o  output  CNT_W  count of good frames; wraps modulo 2^CNT_W.

Behaviour:
- Reset (rst=1 at posedge):
  - state=IDLE, gain_o=RESET_CODE, valid_o=0, frame_err_o=0, frame_cnt_o=0.
  - Shift register=0, bit count=0.
  - Read-back register=RESET_CODE, so sdo=RESET_CODE[WIDTH-1].
  - Reset mid-frame aborts the frame; no commit and no error.
- valid_o defaults to 0 every cycle unless set by a commit.
- IDLE:
  - Read-back register tracks gain_o.
  - On posedge with cs_n=0: shreg <= {shreg[WIDTH-2:0], sdi}, count=1, read-back shifts left by one (zero-fill), go to SHIFT.
  - With cs_n=1: stay in IDLE.
- SHIFT:
  - On posedge with cs_n=0 and count<WIDTH: shift in sdi, count+1, shift read-back.
  - On posedge with cs_n=0 and count==WIDTH: go to OVERRUN; shreg is discarded.
  - On posedge with cs_n=1 and count==WIDTH (commit):
    - gain_o <= shreg, valid_o=1 for that cycle.
    - frame_cnt_o+1.
    - Read-back register <= shreg.
    - Go to IDLE.
  - On posedge with cs_n=1 and count<WIDTH: frame_err_o <= 1, gain_o unchanged, go to IDLE.
- OVERRUN:
  - Ignore sdi while cs_n=0.
  - On cs_n=1: frame_err_o <= 1, no commit, go to IDLE.
- Latency: gain_o and valid_o update on the first posedge sck at which cs_n is sampled high after the WIDTH-th bit.
- busy_o = (state != IDLE).
- frame_err_o is cleared only by rst. A later good frame still commits and does not clear it.
- sdo during a frame:
  - Presents the previous gain_o MSB-first; bit k of the frame appears after the posedge that sampled bit k-1.
  - Bit 0 is valid in IDLE before the frame.
- Back-to-back frames:
  - cs_n high for exactly one posedge between frames is sufficient.
  - A commit and the start of the next frame cannot coincide, because a commit requires cs_n=1.
- frame_cnt_o wraps from 2^CNT_W-1 to 0.

Test Plan:
- Reset, then frame 8'h8F (bits 1,0,0,0,1,1,1,1) with cs_n low for 8 posedges, then high -> gain_o=8'h8F, valid_o high for exactly 1 cycle on the cs_n-high posedge, frame_cnt_o=1, frame_err_o=0.
- Second frame 8'h3C immediately after -> sdo streams 1,0,0,0,1,1,1,1 during the frame; gain_o=8'h3C at the end; frame_cnt_o=2.
- Short frame: 5 bits, then cs_n high -> frame_err_o=1, gain_o stays 8'h3C, no valid_o pulse, frame_cnt_o unchanged.
- Long frame: 10 bits -> state OVERRUN after bit 9, frame_err_o=1 on cs_n rise, gain_o unchanged; a following good frame 8'hA5 commits gain_o=8'hA5 while frame_err_o stays 1.
- Reset mid-frame: assert rst after bit 4 of 8'hFF -> gain_o=RESET_CODE, busy_o=0, frame_err_o=0, no valid_o pulse; the next full frame 8'h01 commits normally.
- Wrap: with CNT_W=2, run 5 good frames -> frame_cnt_o sequence 1,2,3,0,1.

Source files
------------

// File: rtl/pga_spi_responder.sv
// SPI responder for the PGA gain link: deserializes MSB-first frames on sck,
// commits the gain code only on exactly WIDTH-bit frames, and shifts the previous code out on sdo.
module pga_spi_responder #(
    parameter int               WIDTH      = 8,
    parameter logic [WIDTH-1:0] RESET_CODE = '0,
    parameter int               CNT_W      = 8
) (
    input  logic             sck,
    input  logic             rst,
    input  logic             cs_n,
    input  logic             sdi,
    output logic             sdo,
    output logic [WIDTH-1:0] gain_o,
    output logic             valid_o,
    output logic             frame_err_o,
    output logic             busy_o,
    output logic [CNT_W-1:0] frame_cnt_o
);

    localparam int BC_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, OVERRUN} state_t;

    state_t            state, state_nxt;
    logic [WIDTH-1:0]  shreg, shreg_nxt;
    logic [WIDTH-1:0]  rb, rb_nxt;
    logic [BC_W-1:0]   bit_cnt, bit_cnt_nxt;
    logic [WIDTH-1:0]  gain_nxt;
    logic              valid_nxt;
    logic              err_nxt;
    logic [CNT_W-1:0]  fcnt_nxt;

    always_ff @(posedge sck) begin
        if (rst) begin
            state       <= IDLE;
            shreg       <= '0;
            rb          <= RESET_CODE;
            bit_cnt     <= '0;
            gain_o      <= RESET_CODE;
            valid_o     <= 1'b0;
            frame_err_o <= 1'b0;
            frame_cnt_o <= '0;
        end else begin
            state       <= state_nxt;
            shreg       <= shreg_nxt;
            rb          <= rb_nxt;
            bit_cnt     <= bit_cnt_nxt;
            gain_o      <= gain_nxt;
            valid_o     <= valid_nxt;
            frame_err_o <= err_nxt;
            frame_cnt_o <= fcnt_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        shreg_nxt   = shreg;
        rb_nxt      = rb;
        bit_cnt_nxt = bit_cnt;
        gain_nxt    = gain_o;
        valid_nxt   = 1'b0;
        err_nxt     = frame_err_o;
        fcnt_nxt    = frame_cnt_o;
        case (state)
            IDLE: begin
                if (!cs_n) begin
                    shreg_nxt   = {shreg[WIDTH-2:0], sdi};
                    bit_cnt_nxt = BC_W'(1);
                    rb_nxt      = {rb[WIDTH-2:0], 1'b0};
                    state_nxt   = SHIFT;
                end else begin
                    rb_nxt = gain_o;
                end
            end
            SHIFT: begin
                if (!cs_n) begin
                    if (bit_cnt == BC_W'(WIDTH)) begin
                        state_nxt = OVERRUN;
                    end else begin
                        shreg_nxt   = {shreg[WIDTH-2:0], sdi};
                        bit_cnt_nxt = bit_cnt + BC_W'(1);
                        rb_nxt      = {rb[WIDTH-2:0], 1'b0};
                    end
                end else if (bit_cnt == BC_W'(WIDTH)) begin
                    gain_nxt  = shreg;
                    valid_nxt = 1'b1;
                    fcnt_nxt  = frame_cnt_o + CNT_W'(1);
                    rb_nxt    = shreg;
                    state_nxt = IDLE;
                end else begin
                    // Short frame: reload read-back so a following frame starts from gain_o
                    err_nxt   = 1'b1;
                    rb_nxt    = gain_o;
                    state_nxt = IDLE;
                end
            end
            OVERRUN: begin
                if (cs_n) begin
                    err_nxt   = 1'b1;
                    rb_nxt    = gain_o;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign sdo    = rb[WIDTH-1];
    assign busy_o = (state != IDLE);

endmodule

// File: tb/tb_pga_spi_responder.sv
// Directed bench for pga_spi_responder; a second instance with CNT_W=2 covers counter wrap.
module tb_pga_spi_responder;

    logic       sck = 1'b0;
    logic       rst = 1'b1;
    logic       cs_n = 1'b1;
    logic       sdi = 1'b0;
    logic       sdo, valid_o, frame_err_o, busy_o;
    logic [7:0] gain_o, frame_cnt_o;
    logic       sdo2, valid2, err2, busy2;
    logic [7:0] gain2;
    logic [1:0] cnt2;

    int tests = 0;
    int fails = 0;

    pga_spi_responder #(.WIDTH(8), .RESET_CODE(8'h00), .CNT_W(8)) dut (
        .sck(sck), .rst(rst), .cs_n(cs_n), .sdi(sdi), .sdo(sdo),
        .gain_o(gain_o), .valid_o(valid_o), .frame_err_o(frame_err_o),
        .busy_o(busy_o), .frame_cnt_o(frame_cnt_o)
    );

    pga_spi_responder #(.WIDTH(8), .RESET_CODE(8'h00), .CNT_W(2)) dut_wrap (
        .sck(sck), .rst(rst), .cs_n(cs_n), .sdi(sdi), .sdo(sdo2),
        .gain_o(gain2), .valid_o(valid2), .frame_err_o(err2),
        .busy_o(busy2), .frame_cnt_o(cnt2)
    );

    always #5 sck = ~sck;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock with the given cs_n/sdi driven at the negedge; returns #1 after the posedge.
    task automatic tick(input logic c, input logic d);
        @(negedge sck);
        cs_n = c;
        sdi  = d;
        @(posedge sck);
        #1;
    endtask

    // Sends nbits MSB-first from code (zeros past bit 7); optionally checks sdo against prev.
    task automatic send(input logic [7:0] code, input int nbits, input logic chk_sdo,
                        input logic [7:0] prev);
        logic b;
        for (int k = 0; k < nbits; k++) begin
            b = (k < 8) ? code[7-k] : 1'b0;
            @(negedge sck);
            cs_n = 1'b0;
            sdi  = b;
            if (chk_sdo && k < 8) chk($sformatf("sdo_bit%0d", k), 32'(sdo), 32'(prev[7-k]));
            @(posedge sck);
            #1;
            if (k == 0) begin
                chk("busy_first_bit", 32'(busy_o), 32'd1);
                chk("valid_low_in_frame", 32'(valid_o), 32'd0);
            end
        end
    endtask

    initial begin
        // Reset
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b0);
        rst = 1'b0;
        tick(1'b1, 1'b0);
        chk("rst_gain", 32'(gain_o), 32'h00);
        chk("rst_valid", 32'(valid_o), 32'd0);
        chk("rst_err", 32'(frame_err_o), 32'd0);
        chk("rst_cnt", 32'(frame_cnt_o), 32'd0);
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_sdo", 32'(sdo), 32'd0);

        // Good frame 8F
        send(8'h8F, 8, 1'b0, 8'h00);
        chk("f1_gain_before_end", 32'(gain_o), 32'h00);
        tick(1'b1, 1'b0);
        chk("f1_gain", 32'(gain_o), 32'h8F);
        chk("f1_valid", 32'(valid_o), 32'd1);
        chk("f1_cnt", 32'(frame_cnt_o), 32'd1);
        chk("f1_err", 32'(frame_err_o), 32'd0);
        chk("f1_busy", 32'(busy_o), 32'd0);

        // Back-to-back frame 3C, sdo streams the previous code 8F
        send(8'h3C, 8, 1'b1, 8'h8F);
        tick(1'b1, 1'b0);
        chk("f2_gain", 32'(gain_o), 32'h3C);
        chk("f2_valid", 32'(valid_o), 32'd1);
        chk("f2_cnt", 32'(frame_cnt_o), 32'd2);
        tick(1'b1, 1'b0);
        chk("f2_valid_one_cycle", 32'(valid_o), 32'd0);
        chk("idle_sdo_msb", 32'(sdo), 32'd0);

        // Short frame
        send(8'hFF, 5, 1'b0, 8'h00);
        tick(1'b1, 1'b0);
        chk("short_err", 32'(frame_err_o), 32'd1);
        chk("short_gain", 32'(gain_o), 32'h3C);
        chk("short_valid", 32'(valid_o), 32'd0);
        chk("short_cnt", 32'(frame_cnt_o), 32'd2);
        tick(1'b1, 1'b0);

        // Long frame
        send(8'hA5, 10, 1'b0, 8'h00);
        chk("long_overrun_busy", 32'(busy_o), 32'd1);
        chk("long_gain_hold", 32'(gain_o), 32'h3C);
        tick(1'b1, 1'b0);
        chk("long_err", 32'(frame_err_o), 32'd1);
        chk("long_gain", 32'(gain_o), 32'h3C);
        chk("long_valid", 32'(valid_o), 32'd0);
        chk("long_busy", 32'(busy_o), 32'd0);
        chk("long_cnt", 32'(frame_cnt_o), 32'd2);

        // Good frame after errors, sdo streams 3C
        send(8'hA5, 8, 1'b1, 8'h3C);
        tick(1'b1, 1'b0);
        chk("a5_gain", 32'(gain_o), 32'hA5);
        chk("a5_valid", 32'(valid_o), 32'd1);
        chk("a5_cnt", 32'(frame_cnt_o), 32'd3);
        chk("a5_err_sticky", 32'(frame_err_o), 32'd1);
        tick(1'b1, 1'b0);

        // Reset mid-frame
        send(8'hFF, 4, 1'b0, 8'h00);
        rst = 1'b1;
        tick(1'b0, 1'b1);
        chk("midrst_gain", 32'(gain_o), 32'h00);
        chk("midrst_busy", 32'(busy_o), 32'd0);
        chk("midrst_err", 32'(frame_err_o), 32'd0);
        chk("midrst_valid", 32'(valid_o), 32'd0);
        rst = 1'b0;
        tick(1'b1, 1'b0);
        chk("midrst_idle_valid", 32'(valid_o), 32'd0);
        send(8'h01, 8, 1'b1, 8'h00);
        tick(1'b1, 1'b0);
        chk("f01_gain", 32'(gain_o), 32'h01);
        chk("f01_valid", 32'(valid_o), 32'd1);
        chk("f01_cnt", 32'(frame_cnt_o), 32'd1);
        chk("f01_err", 32'(frame_err_o), 32'd0);

        // Counter wrap on the CNT_W=2 instance
        rst = 1'b1;
        tick(1'b1, 1'b0);
        rst = 1'b0;
        tick(1'b1, 1'b0);
        chk("wrap_rst_cnt", 32'(cnt2), 32'd0);
        for (int i = 0; i < 5; i++) begin
            logic [1:0] exp_w;
            exp_w = 2'(i + 1);
            send(8'(8'h10 + i), 8, 1'b0, 8'h00);
            tick(1'b1, 1'b0);
            chk($sformatf("wrap_cnt%0d", i), 32'(cnt2), 32'(exp_w));
            chk($sformatf("wrap_main_cnt%0d", i), 32'(frame_cnt_o), 32'(i + 1));
            chk($sformatf("wrap_gain%0d", i), 32'(gain2), 32'(8'h10 + i));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
